// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Byte-addressed data memory sitting behind the EX/MEM RAM control bundle.
// One load/store request is accepted from IDLE, serviced after WAIT_STATES
// wait cycles, and completed in DONE with a one-cycle Ready pulse. While a
// request is outstanding Busy stalls the pipeline. Loads return size-adjusted,
// sign- or zero-extended data; misaligned or reserved-size accesses raise
// Misaligned_Err together with Ready, write nothing and return zero.
//
// Parameters:
//   ADDR_WIDTH   byte-address width, memory holds 2^ADDR_WIDTH bytes
//   WAIT_STATES  extra cycles between acceptance and completion (0..15)
//
// Ports:
//   clk             rising-edge clock
//   Reset           synchronous active-high reset
//   RAM_Enable      request valid, held stable by the pipeline while Busy=1
//   RAM_RW          1 = store, 0 = load
//   RAM_SE          load sign-extend (1) / zero-extend (0)
//   RAM_Size        00 byte, 01 halfword, 10 word, 11 reserved
//   Address         byte address (little-endian, wraps at the top)
//   DataIn          store data, byte/half taken from the low bits
//   DataOut         registered load result
//   Ready           one-cycle completion pulse
//   Busy            combinational stall request
//   Misaligned_Err  one-cycle error pulse, coincident with Ready

module data_mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  RAM_Enable,
    input  logic                  RAM_RW,
    input  logic                  RAM_SE,
    input  logic [1:0]            RAM_Size,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  Ready,
    output logic                  Busy,
    output logic                  Misaligned_Err
);

    localparam int         MEM_BYTES = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0] wait_cnt;
    logic [7:0] mem [MEM_BYTES];

    // Copy of the accepted request, used while in WAIT and DONE
    logic                  lat_rw;
    logic                  lat_se;
    logic [1:0]            lat_size;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [31:0]           lat_data;

    // Request seen by the load path: with zero wait states the edge entering
    // DONE is the accept edge itself, so the live inputs must be used there.
    logic                  cur_rw;
    logic                  cur_se;
    logic [1:0]            cur_size;
    logic [ADDR_WIDTH-1:0] cur_addr;

    logic                  cur_mis;
    logic                  lat_mis;
    logic                  mem_we;

    logic [ADDR_WIDTH-1:0] cur_a1, cur_a2, cur_a3;
    logic [ADDR_WIDTH-1:0] lat_a1, lat_a2, lat_a3;
    logic [31:0]           rd_word;
    logic [31:0]           load_value;

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lsbs);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lsbs[0];
            SIZE_WORD: bad = (lsbs != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign cur_rw   = (state == IDLE) ? RAM_RW   : lat_rw;
    assign cur_se   = (state == IDLE) ? RAM_SE   : lat_se;
    assign cur_size = (state == IDLE) ? RAM_Size : lat_size;
    assign cur_addr = (state == IDLE) ? Address  : lat_addr;

    assign cur_mis = is_misaligned(cur_size, cur_addr[1:0]);
    assign lat_mis = is_misaligned(lat_size, lat_addr[1:0]);

    // Byte addresses wrap naturally through ADDR_WIDTH-bit arithmetic
    assign cur_a1 = cur_addr + ADDR_WIDTH'(1);
    assign cur_a2 = cur_addr + ADDR_WIDTH'(2);
    assign cur_a3 = cur_addr + ADDR_WIDTH'(3);
    assign lat_a1 = lat_addr + ADDR_WIDTH'(1);
    assign lat_a2 = lat_addr + ADDR_WIDTH'(2);
    assign lat_a3 = lat_addr + ADDR_WIDTH'(3);

    assign rd_word = {mem[cur_a3], mem[cur_a2], mem[cur_a1], mem[cur_addr]};

    // Size adjustment and extension of the little-endian read word
    always_comb begin
        load_value = rd_word;
        case (cur_size)
            SIZE_BYTE: load_value = {{24{cur_se & rd_word[7]}},  rd_word[7:0]};
            SIZE_HALF: load_value = {{16{cur_se & rd_word[15]}}, rd_word[15:0]};
            default:   load_value = rd_word;
        endcase
    end

    // Next-state logic; DONE always returns to IDLE so a held request is
    // only re-accepted after a mandatory IDLE cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (RAM_Enable) begin
                    state_next = (WAIT_INIT == 4'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign Busy           = ((state == IDLE) && RAM_Enable) || (state == WAIT);
    assign Ready          = (state == DONE);
    assign Misaligned_Err = (state == DONE) && lat_mis;
    assign mem_we         = (state == DONE) && lat_rw && !lat_mis;

    // State, wait counter, request latch and load result register
    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            DataOut  <= 32'd0;
            lat_rw   <= 1'b0;
            lat_se   <= 1'b0;
            lat_size <= 2'b00;
            lat_addr <= '0;
            lat_data <= 32'd0;
        end else begin
            state <= state_next;

            if ((state == IDLE) && RAM_Enable) begin
                lat_rw   <= RAM_RW;
                lat_se   <= RAM_SE;
                lat_size <= RAM_Size;
                lat_addr <= Address;
                lat_data <= DataIn;
                wait_cnt <= WAIT_INIT;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            // Result is captured on the edge entering DONE; stores leave it alone
            if (state_next == DONE) begin
                if (cur_mis) begin
                    DataOut <= 32'd0;
                end else if (!cur_rw) begin
                    DataOut <= load_value;
                end
            end
        end
    end

    // Store commit on the edge leaving DONE; memory is never cleared by
    // reset, but a reset on that edge cancels the write.
    always_ff @(posedge clk) begin
        if (!Reset && mem_we) begin
            case (lat_size)
                SIZE_BYTE: begin
                    mem[lat_addr] <= lat_data[7:0];
                end
                SIZE_HALF: begin
                    mem[lat_addr] <= lat_data[7:0];
                    mem[lat_a1]   <= lat_data[15:8];
                end
                default: begin
                    mem[lat_addr] <= lat_data[7:0];
                    mem[lat_a1]   <= lat_data[15:8];
                    mem[lat_a2]   <= lat_data[23:16];
                    mem[lat_a3]   <= lat_data[31:24];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//
// Bench for data_mem_responder. Three instances with WAIT_STATES of 1, 3
// and 0 each get their own request bundle. Ordinary transactions come from
// a vector table and their expected completions go through a scoreboard
// queue; reset-during-request and back-to-back cases are written out by hand.

module tb_data_mem_responder;

    typedef struct packed {
        logic        en;
        logic        rw;
        logic        se;
        logic [1:0]  size;
        logic [8:0]  addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic        rw;
        logic        se;
        logic [1:0]  size;
        logic [8:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_out;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] dout;
        logic        err;
        logic [7:0]  lat;
    } sb_t;

    logic        clk;
    logic        rst  [3];
    req_t        rq   [3];
    logic [31:0] dout [3];
    logic        rdy  [3];
    logic        busy [3];
    logic        merr [3];

    sb_t  sbq [$];
    vec_t vecs [18];

    int checks;
    int fails;

    // Instance 0: one wait state
    data_mem_responder #(.ADDR_WIDTH(9), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .Reset(rst[0]), .RAM_Enable(rq[0].en), .RAM_RW(rq[0].rw),
        .RAM_SE(rq[0].se), .RAM_Size(rq[0].size), .Address(rq[0].addr),
        .DataIn(rq[0].data), .DataOut(dout[0]), .Ready(rdy[0]),
        .Busy(busy[0]), .Misaligned_Err(merr[0])
    );

    // Instance 1: three wait states
    data_mem_responder #(.ADDR_WIDTH(9), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .Reset(rst[1]), .RAM_Enable(rq[1].en), .RAM_RW(rq[1].rw),
        .RAM_SE(rq[1].se), .RAM_Size(rq[1].size), .Address(rq[1].addr),
        .DataIn(rq[1].data), .DataOut(dout[1]), .Ready(rdy[1]),
        .Busy(busy[1]), .Misaligned_Err(merr[1])
    );

    // Instance 2: zero wait states
    data_mem_responder #(.ADDR_WIDTH(9), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .Reset(rst[2]), .RAM_Enable(rq[2].en), .RAM_RW(rq[2].rw),
        .RAM_SE(rq[2].se), .RAM_Size(rq[2].size), .Address(rq[2].addr),
        .DataIn(rq[2].data), .DataOut(dout[2]), .Ready(rdy[2]),
        .Busy(busy[2]), .Misaligned_Err(merr[2])
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck run still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string what, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
        end
    endtask

    // One complete request on instance d; returns once the DUT is idle again
    task automatic applyStimulus(input int d, input int ws, input vec_t v,
                                 input int idx);
        sb_t e;
        bit  seen;
        @(negedge clk);
        rq[d].en   = 1'b1;
        rq[d].rw   = v.rw;
        rq[d].se   = v.se;
        rq[d].size = v.size;
        rq[d].addr = v.addr;
        rq[d].data = v.data;
        e.dout = v.exp_out;
        e.err  = v.exp_err;
        e.lat  = 8'(ws + 1);
        sbq.push_back(e);
        #1;
        checkOutput($sformatf("d%0d v%0d busy_accept", d, idx), 32'(busy[d]), 32'd1);
        seen = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (rdy[d]) begin
                seen = 1'b1;
                rq[d].en = 1'b0;
                e = sbq.pop_front();
                checkOutput($sformatf("d%0d v%0d latency", d, idx), 32'(n), 32'(e.lat));
                checkOutput($sformatf("d%0d v%0d dataout", d, idx), dout[d], e.dout);
                checkOutput($sformatf("d%0d v%0d misaligned", d, idx), 32'(merr[d]), 32'(e.err));
                checkOutput($sformatf("d%0d v%0d busy_done", d, idx), 32'(busy[d]), 32'd0);
            end else begin
                checkOutput($sformatf("d%0d v%0d busy_wait", d, idx), 32'(busy[d]), 32'd1);
                checkOutput($sformatf("d%0d v%0d err_early", d, idx), 32'(merr[d]), 32'd0);
            end
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("[TB] FAIL d%0d v%0d ready_timeout: got no Ready, expected Ready", d, idx);
            rq[d].en = 1'b0;
            void'(sbq.pop_front());
        end
        @(posedge clk);
        #1;
        checkOutput($sformatf("d%0d v%0d ready_after", d, idx), 32'(rdy[d]), 32'd0);
        checkOutput($sformatf("d%0d v%0d busy_after", d, idx), 32'(busy[d]), 32'd0);
    endtask

    function automatic vec_t mk(input logic rw, input logic se, input logic [1:0] size,
                                input logic [8:0] addr, input logic [31:0] data,
                                input logic [31:0] exp_out, input logic exp_err);
        vec_t v;
        v.rw = rw; v.se = se; v.size = size; v.addr = addr; v.data = data;
        v.exp_out = exp_out; v.exp_err = exp_err;
        return v;
    endfunction

    initial begin
        sb_t e;
        bit  seen;
        int  ready_count;

        checks = 0;
        fails  = 0;

        // Main vectors for the one-wait-state instance
        vecs[0]  = mk(1, 0, 2'b10, 9'h010, 32'hDEADBEEF, 32'h00000000, 0);
        vecs[1]  = mk(0, 0, 2'b10, 9'h010, 32'h0,        32'hDEADBEEF, 0);
        vecs[2]  = mk(1, 0, 2'b10, 9'h020, 32'h80FF7F01, 32'hDEADBEEF, 0);
        vecs[3]  = mk(0, 1, 2'b00, 9'h023, 32'h0,        32'hFFFFFF80, 0);
        vecs[4]  = mk(0, 0, 2'b00, 9'h023, 32'h0,        32'h00000080, 0);
        vecs[5]  = mk(0, 1, 2'b01, 9'h022, 32'h0,        32'hFFFF80FF, 0);
        vecs[6]  = mk(0, 0, 2'b01, 9'h020, 32'h0,        32'h00007F01, 0);
        vecs[7]  = mk(1, 0, 2'b10, 9'h020, 32'h11223344, 32'h00007F01, 0);
        vecs[8]  = mk(1, 0, 2'b00, 9'h021, 32'h123456AA, 32'h00007F01, 0);
        vecs[9]  = mk(0, 0, 2'b10, 9'h020, 32'h0,        32'h1122AA44, 0);
        vecs[10] = mk(0, 0, 2'b10, 9'h022, 32'h0,        32'h00000000, 1);
        vecs[11] = mk(1, 0, 2'b10, 9'h030, 32'h55667788, 32'h00000000, 0);
        vecs[12] = mk(1, 0, 2'b01, 9'h031, 32'h0000BEEF, 32'h00000000, 1);
        vecs[13] = mk(1, 0, 2'b11, 9'h030, 32'hFFFFFFFF, 32'h00000000, 1);
        vecs[14] = mk(0, 0, 2'b10, 9'h030, 32'h0,        32'h55667788, 0);
        vecs[15] = mk(0, 1, 2'b01, 9'h020, 32'h0,        32'hFFFFAA44, 0);
        vecs[16] = mk(0, 1, 2'b00, 9'h022, 32'h0,        32'h00000022, 0);
        vecs[17] = mk(0, 1, 2'b10, 9'h010, 32'h0,        32'hDEADBEEF, 0);

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            rq[d]  = '0;
        end

        // Reset state, including Busy following RAM_Enable while in reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("d%0d reset dataout", d), dout[d], 32'd0);
            checkOutput($sformatf("d%0d reset ready", d), 32'(rdy[d]), 32'd0);
            checkOutput($sformatf("d%0d reset busy", d), 32'(busy[d]), 32'd0);
            checkOutput($sformatf("d%0d reset misaligned", d), 32'(merr[d]), 32'd0);
        end
        rq[0].en = 1'b1;
        #1;
        checkOutput("d0 reset busy_follows_enable", 32'(busy[0]), 32'd1);
        rq[0].en = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // Table-driven transactions
        for (int i = 0; i < 18; i++) begin
            applyStimulus(0, 1, vecs[i], i);
        end

        // Reset during the second WAIT cycle aborts a store (WAIT_STATES=3)
        applyStimulus(1, 3, mk(1, 0, 2'b10, 9'h040, 32'hCAFEF00D, 32'h0, 0), 100);
        @(negedge clk);
        rq[1] = '{en: 1'b1, rw: 1'b1, se: 1'b0, size: 2'b10, addr: 9'h040, data: 32'h12345678};
        @(posedge clk);
        #1;
        checkOutput("abort busy_wait1", 32'(busy[1]), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("abort busy_wait2", 32'(busy[1]), 32'd1);
        rst[1]   = 1'b1;
        rq[1].en = 1'b0;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        checkOutput("abort busy_after_reset", 32'(busy[1]), 32'd0);
        ready_count = 0;
        for (int n = 0; n < 6; n++) begin
            if (rdy[1]) ready_count++;
            @(posedge clk);
            #1;
        end
        checkOutput("abort no_ready", 32'(ready_count), 32'd0);
        applyStimulus(1, 3, mk(0, 0, 2'b10, 9'h040, 32'h0, 32'hCAFEF00D, 0), 101);

        // Reset on the edge ending DONE cancels the store commit
        applyStimulus(1, 3, mk(1, 0, 2'b10, 9'h044, 32'h01020304, 32'hCAFEF00D, 0), 102);
        @(negedge clk);
        rq[1] = '{en: 1'b1, rw: 1'b1, se: 1'b0, size: 2'b10, addr: 9'h044, data: 32'h77777777};
        seen = 1'b0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (rdy[1]) seen = 1'b1;
        end
        checkOutput("done_reset ready_seen", 32'(seen), 32'd1);
        rst[1]   = 1'b1;
        rq[1].en = 1'b0;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        checkOutput("done_reset dataout", dout[1], 32'd0);
        applyStimulus(1, 3, mk(0, 0, 2'b10, 9'h044, 32'h0, 32'h01020304, 0), 103);

        // Zero wait states: two loads held back to back
        applyStimulus(2, 0, mk(1, 0, 2'b10, 9'h008, 32'h0BADF00D, 32'h0, 0), 200);
        applyStimulus(2, 0, mk(1, 0, 2'b10, 9'h00C, 32'h600DCAFE, 32'h0, 0), 201);
        @(negedge clk);
        rq[2] = '{en: 1'b1, rw: 1'b0, se: 1'b0, size: 2'b10, addr: 9'h008, data: 32'h0};
        e.dout = 32'h0BADF00D; e.err = 1'b0; e.lat = 8'd1;
        sbq.push_back(e);
        #1;
        checkOutput("b2b busy_T", 32'(busy[2]), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("b2b ready_T1", 32'(rdy[2]), 32'd1);
        checkOutput("b2b busy_T1", 32'(busy[2]), 32'd0);
        e = sbq.pop_front();
        checkOutput("b2b dataout_T1", dout[2], e.dout);
        rq[2].addr = 9'h00C;
        e.dout = 32'h600DCAFE;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        checkOutput("b2b ready_T2", 32'(rdy[2]), 32'd0);
        checkOutput("b2b busy_T2", 32'(busy[2]), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("b2b ready_T3", 32'(rdy[2]), 32'd1);
        checkOutput("b2b busy_T3", 32'(busy[2]), 32'd0);
        e = sbq.pop_front();
        checkOutput("b2b dataout_T3", dout[2], e.dout);
        rq[2].en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("b2b ready_T4", 32'(rdy[2]), 32'd0);
        checkOutput("b2b busy_T4", 32'(busy[2]), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("b2b ready_T5", 32'(rdy[2]), 32'd0);

        checkOutput("scoreboard drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder at the far end of the EX/MEM pipeline register's RAM control bundle (RAM_Enable, RAM_RW, RAM_SE, RAM_Size). It accepts one load/store request at a time and services it after a programmable number of wait states. While a request is outstanding it drives a stall back to the pipeline. It returns size-adjusted, sign- or zero-extended load data with a one-cycle completion pulse, and flags misaligned accesses.

## Interface
- ADDR_WIDTH, 9: byte-address width; memory holds 2^ADDR_WIDTH bytes.
- WAIT_STATES, 1: extra cycles between acceptance and completion; legal range 0–15.

- clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- RAM_Enable  in  1  request valid; held stable by the pipeline while Busy=1.
- RAM_RW  in  1  1 = store, 0 = load.
- RAM_SE  in  1  load sign-extend (1) / zero-extend (0); ignored for stores and words.
- RAM_Size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- Address  in  ADDR_WIDTH  byte address.
- DataIn  in  32  store data; byte/half taken from low bits.
- DataOut  out  32  load result, registered.
- Ready  out  1  one-cycle completion pulse.
- Busy  out  1  stall request to hazard logic (combinational).
- Misaligned_Err  out  1  one-cycle error pulse, coincident with Ready.

## Operation
- FSM states: IDLE, WAIT, DONE. A 4-bit wait counter is used.
- IDLE with RAM_Enable=1:
  - latch Address, DataIn, RAM_RW, RAM_SE, RAM_Size;
  - load the counter with WAIT_STATES;
  - go to WAIT, or go directly to DONE if WAIT_STATES=0.
- WAIT:
  - counter decrements each cycle;
  - the cycle the counter reads 1, go to DONE;
  - request inputs are ignored (latched copy used).
- DONE: Ready=1 for exactly one cycle, then unconditionally go to IDLE. The same still-held request is never re-accepted.
- Busy = (IDLE && RAM_Enable) || WAIT. Busy is 0 in DONE, so the pipeline advances on the edge ending DONE.
- Memory layout: byte array, little-endian. Word at A is bytes A..A+3 with A the LSB.
- Alignment:
  - halfword requires addr[0]=0;
  - word requires addr[1:0]=00;
  - size 11 is always an error.
  - On error: no memory write, DataOut loads 0, Misaligned_Err=1 in DONE.
- Loads:
  - DataOut is loaded on the edge entering DONE;
  - byte: {24{SE & b[7]}, b};
  - half: {16{SE & h[15]}, h};
  - word: as stored.
- Stores: the write commits on the edge ending DONE, unless Reset=1 on that edge. DataOut keeps its previous value.
- DataOut holds its value until the next load/error completion or reset.
- Reset:
  - state=IDLE, counter=0, DataOut=0, Ready=0, Misaligned_Err=0, Busy follows its equation (0 unless RAM_Enable);
  - reset aborts any in-flight request with no memory side effect;
  - memory contents are not cleared.
- Address upper bound: accesses whose last byte exceeds 2^ADDR_WIDTH−1 wrap modulo 2^ADDR_WIDTH.

## Timing
- Request present in IDLE at cycle T (Busy=1 in T).
- WAIT occupies T+1 … T+WAIT_STATES.
- DONE/Ready at T+WAIT_STATES+1. For WAIT_STATES=0, Ready is at T+1.
- Load data is valid in the Ready cycle. Store data is visible to a load accepted at the earliest at the cycle after DONE.
- Back-to-back requests: minimum spacing is WAIT_STATES+2 cycles (the IDLE accept cycle is mandatory).
- Reset asserted in any cycle takes effect at that edge and overrides every state transition and write.

## Test plan
- Word store then load, WAIT_STATES=1:
  - store 0xDEADBEEF to 0x010;
  - store Ready at T+2, Busy high T..T+1;
  - load 0x010 → DataOut=0xDEADBEEF with Ready.
- Byte/half extension with memory 0x80FF_7F01 at 0x020:
  - LB SE=1 @0x023 → 0xFFFFFF80;
  - LBU @0x023 → 0x00000080;
  - LH SE=1 @0x022 → 0xFFFF80FF;
  - LHU @0x020 → 0x00007F01.
- Partial stores: SB 0xAA to 0x021 over word 0x11223344 at 0x020 → word load gives 0x1122AA44; neighbouring bytes unchanged.
- Misalignment:
  - LW @0x022 → Misaligned_Err and Ready coincident, DataOut=0;
  - SH @0x031 and size=11 store → memory unchanged.
- Reset mid-WAIT (WAIT_STATES=3):
  - SW 0x12345678 to 0x040 with Reset pulsed during the second WAIT cycle;
  - no Ready pulse;
  - subsequent LW 0x040 returns the prior contents.
- WAIT_STATES=0 back-to-back:
  - two loads held one after another;
  - Ready at T+1 and T+3;
  - Busy=0 in each DONE cycle;
  - no duplicate acceptance.
